// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue: entry field layout and control-transfer opcodes.
// Entry packing is {pc, pred_target, pred_taken}, sized from the address width.
package branch_resolve_queue_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int TAKEN_BIT  = 0;
  localparam int TARGET_LSB = 1;

  function automatic int pc_lsb(input int xlen);
    return xlen + 1;
  endfunction

  function automatic int entry_w(input int xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc high, holds at all-ones.
// Single-cycle update, no backpressure.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds fetch-time branch predictions until execute resolves them; compares and redirects combinationally.
// Pop/redirect are same-cycle with resolve; pushes while full without a pop are dropped (ovf_err).
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid,
  input  logic [XLEN-1:0]  push_pc,
  input  logic             push_pred_taken,
  input  logic [XLEN-1:0]  push_pred_target,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [XLEN-1:0]  resolve_target,
  input  logic             flush,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             state_update_en,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int AW     = $clog2(DEPTH) + 1;
  localparam int IW     = AW - 1;
  localparam int EW     = entry_w(XLEN);
  localparam int PC_LSB = pc_lsb(XLEN);

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, count;
  logic [EW-1:0]   head;
  logic [XLEN-1:0] head_pc, head_target;
  logic            head_taken;
  logic            pop, push_ok, discard;

  assign head        = mem[rd_ptr[IW-1:0]];
  assign head_pc     = head[PC_LSB +: XLEN];
  assign head_target = head[TARGET_LSB +: XLEN];
  assign head_taken  = head[TAKEN_BIT];

  assign full  = (count == AW'(DEPTH));
  assign empty = (count == '0);

  assign pop             = resolve_valid && !empty;
  assign state_update_en = pop;

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (pop) begin
      mispredict = (resolve_taken != head_taken) ||
                   (resolve_taken && (resolve_target != head_target));
      if (mispredict) begin
        redirect_pc = resolve_taken ? resolve_target : head_pc + XLEN'(4);
      end
    end
  end

  // Anything fetched alongside a flush or a mispredict is wrong-path and never enters.
  assign discard = flush || mispredict;
  assign push_ok = push_valid && !discard && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[IW-1:0]] <= {push_pc, push_pred_target, push_pred_taken};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (discard) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + AW'(1);
      else if (!push_ok && pop) count <= count - AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (push_valid && !discard && full && !pop) ovf_err <= 1'b1;
      if (resolve_valid && empty)                 unf_err <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (state_update_en),
    .cnt     (branch_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (mispredict),
    .cnt     (mispredict_count)
  );

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: queue-based reference model checked every cycle plus literal spot checks.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic        push_pred_taken = 1'b0;
  logic [31:0] push_pred_target = '0;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        flush = 1'b0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        state_update_en;
  logic        full;
  logic        empty;
  logic        ovf_err;
  logic        unf_err;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_vec = 0;
  int n_bad = 0;

  branch_resolve_queue #(.DEPTH(DEPTH), .XLEN(32), .CNT_W(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .push_valid       (push_valid),
    .push_pc          (push_pc),
    .push_pred_taken  (push_pred_taken),
    .push_pred_target (push_pred_target),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .flush            (flush),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .state_update_en  (state_update_en),
    .full             (full),
    .empty            (empty),
    .ovf_err          (ovf_err),
    .unf_err          (unf_err),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of predictions plus sticky flags and counters.
  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
  } ent_t;

  ent_t        mq[$];
  logic        m_ovf, m_unf;
  logic [31:0] m_bc, m_mc;
  logic        e_sue, e_mis;
  logic [31:0] e_rpc;

  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_bc  = '0;
      m_mc  = '0;
    end else begin
      e_sue = resolve_valid && (mq.size() > 0);
      e_mis = 1'b0;
      e_rpc = '0;
      if (e_sue) begin
        e_mis = (resolve_taken != mq[0].tk) || (resolve_taken && (resolve_target != mq[0].tg));
        if (e_mis) e_rpc = resolve_taken ? resolve_target : mq[0].pc + 32'd4;
      end
      check("m_state_update_en", 64'(state_update_en), 64'(e_sue));
      check("m_mispredict", 64'(mispredict), 64'(e_mis));
      check("m_redirect_pc", 64'(redirect_pc), 64'(e_rpc));
      check("m_full", 64'(full), 64'(mq.size() == DEPTH));
      check("m_empty", 64'(empty), 64'(mq.size() == 0));
      check("m_ovf_err", 64'(ovf_err), 64'(m_ovf));
      check("m_unf_err", 64'(unf_err), 64'(m_unf));
      check("m_branch_count", 64'(branch_count), 64'(m_bc));
      check("m_mispredict_count", 64'(mispredict_count), 64'(m_mc));
      if (e_sue && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      if (e_mis && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      if (resolve_valid && mq.size() == 0) m_unf = 1'b1;
      if (flush || e_mis) begin
        mq.delete();
      end else begin
        if (e_sue) void'(mq.pop_front());
        if (push_valid) begin
          if (mq.size() < DEPTH) mq.push_back('{push_pc, push_pred_taken, push_pred_target});
          else m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic idle();
    push_valid    = 1'b0;
    resolve_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    push_valid       = 1'b1;
    push_pc          = pc;
    push_pred_taken  = tk;
    push_pred_target = tg;
  endtask

  task automatic set_res(input logic tk, input logic [31:0] tg);
    resolve_valid  = 1'b1;
    resolve_taken  = tk;
    resolve_target = tg;
  endtask

  initial begin
    #2;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_bc", 64'(branch_count), 64'd0);
    #10 reset_n = 1'b1;
    tick();

    // Correct not-taken prediction.
    set_push(32'h100, 1'b0, 32'h140); tick();
    set_res(1'b0, 32'h0); #1;
    check("t1_sue", 64'(state_update_en), 64'd1);
    check("t1_mis", 64'(mispredict), 64'd0);
    tick();
    check("t1_bc", 64'(branch_count), 64'd1);

    // Predicted not-taken, actually taken.
    set_push(32'h200, 1'b0, 32'h260); tick();
    set_res(1'b1, 32'h260); #1;
    check("t2_mis", 64'(mispredict), 64'd1);
    check("t2_rpc", 64'(redirect_pc), 64'h260);
    tick();
    check("t2_mc", 64'(mispredict_count), 64'd1);
    check("t2_empty", 64'(empty), 64'd1);

    // Predicted taken, actually not taken: fall through to pc+4.
    set_push(32'h300, 1'b1, 32'h280); tick();
    set_res(1'b0, 32'h0); #1;
    check("t3_mis", 64'(mispredict), 64'd1);
    check("t3_rpc", 64'(redirect_pc), 64'h304);
    tick();

    // Mispredict on head with a simultaneous push drops everything younger.
    for (int i = 0; i < 3; i++) begin
      set_push(32'h400 + 32'(i) * 32'h10, 1'b0, 32'h800); tick();
    end
    set_res(1'b1, 32'h500);
    set_push(32'h430, 1'b0, 32'h800); #1;
    check("t4_mis", 64'(mispredict), 64'd1);
    tick();
    check("t4_empty", 64'(empty), 64'd1);
    check("t4_ovf", 64'(ovf_err), 64'd0);
    tick();

    // Fill, overflow, then push+pop while full across pointer wrap.
    for (int i = 1; i <= 4; i++) begin
      set_push(32'(i) * 32'h10, 1'b1, 32'h1000 + 32'(i)); tick();
    end
    check("t5_full", 64'(full), 64'd1);
    set_push(32'h50, 1'b1, 32'h1005); tick();
    check("t5_ovf", 64'(ovf_err), 64'd1);
    set_push(32'h60, 1'b1, 32'h1006);
    set_res(1'b1, 32'h1001); tick();
    check("t5_full_kept", 64'(full), 64'd1);
    begin
      logic [31:0] order [4];
      order[0] = 32'h1002; order[1] = 32'h1003; order[2] = 32'h1004; order[3] = 32'h1006;
      for (int i = 0; i < 4; i++) begin
        set_res(1'b1, order[i]); #1;
        check("t5_order_mis", 64'(mispredict), 64'd0);
        tick();
      end
    end
    check("t5_empty", 64'(empty), 64'd1);

    // Resolve with nothing queued.
    set_res(1'b0, 32'h0); #1;
    check("t6_sue", 64'(state_update_en), 64'd0);
    tick();
    check("t6_unf", 64'(unf_err), 64'd1);

    // External flush with a same-cycle correct resolve and push.
    set_push(32'h700, 1'b0, 32'h0); tick();
    set_push(32'h710, 1'b0, 32'h0); tick();
    flush = 1'b1;
    set_res(1'b0, 32'h0);
    set_push(32'h720, 1'b0, 32'h0); #1;
    check("t7_sue", 64'(state_update_en), 64'd1);
    tick();
    check("t7_empty", 64'(empty), 64'd1);

    // Asynchronous reset in mid-cycle with entries queued.
    set_push(32'h900, 1'b1, 32'h940); tick();
    set_push(32'h910, 1'b1, 32'h950); tick();
    set_res(1'b0, 32'h0);
    #1 reset_n = 1'b0;
    #1;
    check("t8_empty", 64'(empty), 64'd1);
    check("t8_sue", 64'(state_update_en), 64'd0);
    check("t8_mis", 64'(mispredict), 64'd0);
    check("t8_rpc", 64'(redirect_pc), 64'd0);
    check("t8_ovf", 64'(ovf_err), 64'd0);
    check("t8_unf", 64'(unf_err), 64'd0);
    check("t8_bc", 64'(branch_count), 64'd0);
    check("t8_mc", 64'(mispredict_count), 64'd0);
    idle();
    #10 reset_n = 1'b1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
